// File: rtl/compute_array_sequencer.sv
// compute_array_sequencer: issues add/sub/mul vector commands onto the compute array's registered input buses, tracks them through the fixed latencies and returns results in order through a ready/valid FIFO
module compute_array_sequencer #(
  parameter int DATA_WIDTH  = 50,
  parameter int ARRAY_SIZE  = 256,
  parameter int TAG_WIDTH   = 8,
  parameter int ADD_LATENCY = 2,
  parameter int MUL_LATENCY = 6,
  parameter int RES_DEPTH   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  input  logic [1:0]                         cmd_op,
  input  logic [5:0]                         cmd_limb_id,
  input  logic [TAG_WIDTH-1:0]               cmd_tag,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   cmd_in0,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   cmd_in1,
  output logic                               ctrl_ma,
  output logic [ARRAY_SIZE*6-1:0]            limb_id_add_bus,
  output logic [ARRAY_SIZE*6-1:0]            limb_id_mul_bus,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   add_in0_bus,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   add_in1_bus,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   mult_in0_bus,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   mult_in1_bus,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   add_out_bus,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   mult_out_bus,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   res_data,
  output logic [TAG_WIDTH-1:0]               res_tag,
  output logic [1:0]                         res_op,
  output logic                               err_reserved_op
);
  localparam int BW = ARRAY_SIZE*DATA_WIDTH;
  localparam int CW = $clog2(RES_DEPTH+1);
  localparam int PW = $clog2(RES_DEPTH);
  localparam int DW = $clog2(MUL_LATENCY+1);
  localparam logic [DW-1:0] ADD_L = DW'(ADD_LATENCY);
  localparam logic [DW-1:0] MUL_L = DW'(MUL_LATENCY);
  logic                 p_v   [MUL_LATENCY+1];
  logic [1:0]           p_op  [MUL_LATENCY+1];
  logic [TAG_WIDTH-1:0] p_tag [MUL_LATENCY+1];
  logic [BW-1:0]        fifo_data [RES_DEPTH];
  logic [TAG_WIDTH-1:0] fifo_tag  [RES_DEPTH];
  logic [1:0]           fifo_op   [RES_DEPTH];
  logic [DW-1:0] drain, drain_dec, lat;
  logic [CW-1:0] occ, inflight;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic issue, issue_arr, is_add, is_mul, add_done, mul_done, wr_en, pop;
  assign lat       = cmd_op == 2'd2 ? MUL_L : ADD_L;
  assign drain_dec = drain == '0 ? '0 : drain - 1'b1;
  // lat >= drain is lat > drain-1: the new command finishes strictly after every in-flight one
  assign cmd_ready = cmd_op == 2'd3 ? inflight == '0
                   : (({1'b0, occ} + {1'b0, inflight}) < (CW+1)'(RES_DEPTH)) && lat >= drain;
  assign issue     = cmd_valid && cmd_ready;
  assign issue_arr = issue && cmd_op != 2'd3;
  assign is_add    = issue_arr && !cmd_op[1];
  assign is_mul    = issue_arr && cmd_op == 2'd2;
  assign add_done  = p_v[ADD_LATENCY] && p_op[ADD_LATENCY] != 2'd2;
  assign mul_done  = p_v[MUL_LATENCY] && p_op[MUL_LATENCY] == 2'd2;
  assign wr_en     = add_done || mul_done;
  assign res_valid = occ != '0;
  assign pop       = res_valid && res_ready;
  assign res_data  = res_valid ? fifo_data[rd_ptr] : '0;
  assign res_tag   = res_valid ? fifo_tag[rd_ptr] : '0;
  assign res_op    = res_valid ? fifo_op[rd_ptr] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_ma         <= 1'b0;
      add_in0_bus     <= '0;
      add_in1_bus     <= '0;
      mult_in0_bus    <= '0;
      mult_in1_bus    <= '0;
      limb_id_add_bus <= '0;
      limb_id_mul_bus <= '0;
    end else begin
      ctrl_ma         <= issue_arr && cmd_op == 2'd1;
      add_in0_bus     <= is_add ? cmd_in0 : '0;
      add_in1_bus     <= is_add ? cmd_in1 : '0;
      mult_in0_bus    <= is_mul ? cmd_in0 : '0;
      mult_in1_bus    <= is_mul ? cmd_in1 : '0;
      limb_id_add_bus <= is_add ? {ARRAY_SIZE{cmd_limb_id}} : '0;
      limb_id_mul_bus <= is_mul ? {ARRAY_SIZE{cmd_limb_id}} : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= MUL_LATENCY; i++) begin
        p_v[i]   <= 1'b0;
        p_op[i]  <= '0;
        p_tag[i] <= '0;
      end
    end else begin
      p_v[0]   <= issue_arr;
      p_op[0]  <= cmd_op;
      p_tag[0] <= cmd_tag;
      for (int i = 1; i <= MUL_LATENCY; i++) begin
        p_v[i]   <= p_v[i-1];
        p_op[i]  <= p_op[i-1];
        p_tag[i] <= p_tag[i-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      drain           <= '0;
      occ             <= '0;
      inflight        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      err_reserved_op <= 1'b0;
    end else begin
      drain           <= issue_arr ? (drain_dec > lat ? drain_dec : lat) : drain_dec;
      occ             <= occ + CW'(wr_en) - CW'(pop);
      inflight        <= inflight + CW'(issue_arr) - CW'(wr_en);
      wr_ptr          <= wr_en ? (wr_ptr == PW'(RES_DEPTH-1) ? '0 : wr_ptr + 1'b1) : wr_ptr;
      rd_ptr          <= pop ? (rd_ptr == PW'(RES_DEPTH-1) ? '0 : rd_ptr + 1'b1) : rd_ptr;
      err_reserved_op <= err_reserved_op || (issue && cmd_op == 2'd3);
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_data[wr_ptr] <= add_done ? add_out_bus : mult_out_bus;
      fifo_tag[wr_ptr]  <= add_done ? p_tag[ADD_LATENCY] : p_tag[MUL_LATENCY];
      fifo_op[wr_ptr]   <= add_done ? p_op[ADD_LATENCY] : p_op[MUL_LATENCY];
    end
  end
  always @(posedge clk)
    if (!rst) assert (!(wr_en && !pop && occ == CW'(RES_DEPTH)));
endmodule

// File: tb/tb_compute_array_sequencer.sv
// tb_compute_array_sequencer: directed vectors and corner sequences for compute_array_sequencer against a behavioural array model
module tb_compute_array_sequencer;
  localparam int DW = 50;
  localparam int AS = 256;
  localparam int BW = AS*DW;
  localparam int LW = AS*6;
  localparam int AL = 2;
  localparam int ML = 6;
  localparam logic [DW-1:0] Q = 50'h3_FFFF_FFFF_FFDD;
  logic clk = 0;
  logic rst = 1;
  logic cmd_valid = 0, cmd_ready, ctrl_ma, res_valid, res_ready = 1, err_reserved_op;
  logic [1:0] cmd_op = 0, res_op;
  logic [5:0] cmd_limb_id = 0;
  logic [7:0] cmd_tag = 0, res_tag;
  logic [BW-1:0] cmd_in0 = '0, cmd_in1 = '0;
  logic [LW-1:0] limb_id_add_bus, limb_id_mul_bus;
  logic [BW-1:0] add_in0_bus, add_in1_bus, mult_in0_bus, mult_in1_bus;
  logic [BW-1:0] add_out_bus, mult_out_bus, res_data;
  logic [BW-1:0] add_pipe [AL];
  logic [BW-1:0] mul_pipe [ML];
  logic [7:0] q_tag [$];
  logic [DW-1:0] q_dat [$];
  int tests = 0, fails = 0, cyc = 0;

  compute_array_sequencer #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .TAG_WIDTH(8),
    .ADD_LATENCY(AL), .MUL_LATENCY(ML), .RES_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_limb_id(cmd_limb_id), .cmd_tag(cmd_tag), .cmd_in0(cmd_in0), .cmd_in1(cmd_in1),
    .ctrl_ma(ctrl_ma), .limb_id_add_bus(limb_id_add_bus), .limb_id_mul_bus(limb_id_mul_bus),
    .add_in0_bus(add_in0_bus), .add_in1_bus(add_in1_bus), .mult_in0_bus(mult_in0_bus),
    .mult_in1_bus(mult_in1_bus), .add_out_bus(add_out_bus), .mult_out_bus(mult_out_bus),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .res_op(res_op), .err_reserved_op(err_reserved_op));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BW-1:0] rep(input logic [DW-1:0] v);
    logic [BW-1:0] r;
    for (int i = 0; i < AS; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [BW-1:0] arr_add(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sub);
    logic [BW-1:0] r;
    logic [DW:0] x, y, s;
    for (int i = 0; i < AS; i++) begin
      x = {1'b0, a[i*DW +: DW]};
      y = {1'b0, b[i*DW +: DW]};
      if (sub) s = x >= y ? x - y : x + {1'b0, Q} - y;
      else s = x + y >= {1'b0, Q} ? x + y - {1'b0, Q} : x + y;
      r[i*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] arr_mul(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic [2*DW-1:0] p;
    for (int i = 0; i < AS; i++) begin
      p = {{DW{1'b0}}, a[i*DW +: DW]} * {{DW{1'b0}}, b[i*DW +: DW]};
      p = p % {{DW{1'b0}}, Q};
      r[i*DW +: DW] = p[DW-1:0];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    add_pipe[0] <= arr_add(add_in0_bus, add_in1_bus, ctrl_ma);
    for (int i = 1; i < AL; i++) add_pipe[i] <= add_pipe[i-1];
    mul_pipe[0] <= arr_mul(mult_in0_bus, mult_in1_bus);
    for (int i = 1; i < ML; i++) mul_pipe[i] <= mul_pipe[i-1];
  end
  assign add_out_bus  = add_pipe[AL-1];
  assign mult_out_bus = mul_pipe[ML-1];

  always @(posedge clk)
    if (!rst && res_valid && res_ready) begin
      q_tag.push_back(res_tag);
      q_dat.push_back(res_data[DW-1:0]);
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_bus(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: lane0 got %0h expected %0h, last lane got %0h expected %0h",
               name, act[DW-1:0], exp[DW-1:0], act[BW-1 -: DW], exp[BW-1 -: DW]);
    end
  endtask

  function automatic logic [7:0] qt(input int i);
    return i < q_tag.size() ? q_tag[i] : 8'hEE;
  endfunction

  function automatic logic [DW-1:0] qd(input int i);
    return i < q_dat.size() ? q_dat[i] : '1;
  endfunction

  typedef struct {
    logic [1:0]    op;
    logic [5:0]    limb;
    logic [7:0]    tag;
    logic [DW-1:0] a, b, e;
    int            lat;
  } vec_t;
  vec_t vt [6];

  int idx, t0;
  logic acc, act;

  task automatic push_step();
    @(negedge clk);
    cmd_valid = idx < 6;
    cmd_op = 2'd0;
    cmd_tag = 8'h40 + 8'(idx);
    cmd_in0 = rep(DW'(idx));
    cmd_in1 = rep(DW'(1));
    #1 acc = cmd_valid && cmd_ready;
    @(posedge clk);
    if (acc) idx++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'd0, 6'd0,  8'h11, 50'd5,  50'd7,     50'd12,     4};
    vt[1] = '{2'd1, 6'd0,  8'h12, 50'd3,  50'd5,     Q - 50'd2,  4};
    vt[2] = '{2'd0, 6'd32, 8'h13, Q - 50'd1, 50'd3,  50'd2,      4};
    vt[3] = '{2'd1, 6'd7,  8'h14, 50'd9,  50'd4,     50'd5,      4};
    vt[4] = '{2'd2, 6'd5,  8'h15, 50'd0,  50'd12345, 50'd0,      8};
    vt[5] = '{2'd2, 6'd1,  8'h16, 50'd3,  50'd4,     50'd12,     8};

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk_bus("rst_res_data", res_data, '0);
    chk("rst_res_tag", res_tag, 0);
    chk("rst_res_op", res_op, 0);
    chk("rst_ctrl_ma", ctrl_ma, 0);
    chk("rst_err", err_reserved_op, 0);
    chk_bus("rst_add_in0", add_in0_bus, '0);
    chk_bus("rst_mult_in1", mult_in1_bus, '0);
    act = 0;
    repeat (10) begin
      @(negedge clk);
      act = act | (|{add_in0_bus, add_in1_bus, mult_in0_bus, mult_in1_bus,
                     limb_id_add_bus, limb_id_mul_bus, ctrl_ma, res_valid});
    end
    chk("idle_quiet", act, 0);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_valid = 1;
      cmd_op = vt[i].op;
      cmd_limb_id = vt[i].limb;
      cmd_tag = vt[i].tag;
      cmd_in0 = rep(vt[i].a);
      cmd_in1 = rep(vt[i].b);
      #1 chk($sformatf("vec%0d_ready", i), cmd_ready, 1);
      t0 = cyc;
      @(posedge clk);
      #1 cmd_valid = 0;
      @(negedge clk);
      chk_bus($sformatf("vec%0d_add_in0", i), add_in0_bus, vt[i].op != 2 ? rep(vt[i].a) : '0);
      chk_bus($sformatf("vec%0d_add_in1", i), add_in1_bus, vt[i].op != 2 ? rep(vt[i].b) : '0);
      chk_bus($sformatf("vec%0d_mult_in0", i), mult_in0_bus, vt[i].op == 2 ? rep(vt[i].a) : '0);
      chk_bus($sformatf("vec%0d_mult_in1", i), mult_in1_bus, vt[i].op == 2 ? rep(vt[i].b) : '0);
      chk_bus($sformatf("vec%0d_limb_add", i), BW'(limb_id_add_bus), vt[i].op != 2 ? BW'({AS{vt[i].limb}}) : '0);
      chk_bus($sformatf("vec%0d_limb_mul", i), BW'(limb_id_mul_bus), vt[i].op == 2 ? BW'({AS{vt[i].limb}}) : '0);
      chk($sformatf("vec%0d_ctrl_ma", i), ctrl_ma, vt[i].op == 1);
      while (!res_valid && cyc < t0 + 20) @(negedge clk);
      chk($sformatf("vec%0d_latency", i), cyc - t0, vt[i].lat);
      chk_bus($sformatf("vec%0d_res_data", i), res_data, rep(vt[i].e));
      chk($sformatf("vec%0d_res_tag", i), res_tag, vt[i].tag);
      chk($sformatf("vec%0d_res_op", i), res_op, vt[i].op);
      @(negedge clk);
      chk($sformatf("vec%0d_popped", i), res_valid, 0);
    end

    q_tag.delete();
    q_dat.delete();
    @(negedge clk);
    cmd_valid = 1;
    cmd_op = 2'd2;
    cmd_limb_id = 6'd3;
    cmd_tag = 8'h01;
    cmd_in0 = rep(50'd0);
    cmd_in1 = rep(50'd7);
    #1 chk("mul_first_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_op = 2'd0;
    cmd_tag = 8'h02;
    cmd_in0 = rep(50'd10);
    cmd_in1 = rep(50'd20);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("add_stall_c%0d", k), cmd_ready, 0);
    end
    @(negedge clk);
    chk("add_accept_c5", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 0;
    for (int k = 0; k < 20 && q_tag.size() < 2; k++) @(negedge clk);
    chk("order_count", q_tag.size(), 2);
    chk("order_tag0", qt(0), 8'h01);
    chk("order_tag1", qt(1), 8'h02);
    chk("order_dat0", qd(0), 0);
    chk("order_dat1", qd(1), 30);

    q_tag.delete();
    q_dat.delete();
    res_ready = 0;
    idx = 0;
    for (int c = 0; c < 12; c++) push_step();
    chk("bp_accepted", idx, 4);
    @(negedge clk);
    #1 chk("bp_ready_full", cmd_ready, 0);
    res_ready = 1;
    @(posedge clk);
    @(negedge clk);
    #1 chk("bp_ready_after_pop", cmd_ready, 1);
    acc = cmd_valid && cmd_ready;
    @(posedge clk);
    if (acc) idx++;
    for (int c = 0; c < 12 && idx < 6; c++) push_step();
    #1 cmd_valid = 0;
    for (int k = 0; k < 30 && q_tag.size() < 6; k++) @(negedge clk);
    chk("bp_count", q_tag.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bp_tag%0d", i), qt(i), 8'h40 + 8'(i));
      chk($sformatf("bp_dat%0d", i), qd(i), 64'(i + 1));
    end

    q_tag.delete();
    q_dat.delete();
    @(negedge clk);
    cmd_valid = 1;
    cmd_op = 2'd3;
    cmd_tag = 8'h77;
    #1 chk("rsv_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 0;
    cmd_op = 2'd0;
    @(negedge clk);
    chk("rsv_err_set", err_reserved_op, 1);
    chk("rsv_no_array", |{add_in0_bus, add_in1_bus, mult_in0_bus, mult_in1_bus,
                          limb_id_add_bus, limb_id_mul_bus, ctrl_ma}, 0);
    repeat (10) @(negedge clk);
    chk("rsv_no_result", q_tag.size() + int'(res_valid), 0);
    @(negedge clk);
    cmd_valid = 1;
    cmd_op = 2'd2;
    cmd_tag = 8'h81;
    cmd_in0 = rep(50'd1);
    cmd_in1 = rep(50'd1);
    #1 chk("rst_mul0_ready", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_tag = 8'h82;
    @(negedge clk);
    #1 chk("rst_mul1_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 0;
    cmd_op = 2'd3;
    @(negedge clk);
    #1 chk("rsv_busy", cmd_ready, 0);
    cmd_op = 2'd0;
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    act = 0;
    repeat (12) begin
      @(negedge clk);
      act = act | res_valid;
    end
    chk("midrst_no_valid", act, 0);
    chk("midrst_no_pops", q_tag.size(), 0);
    chk("midrst_err_clr", err_reserved_op, 0);
    chk("midrst_ready", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/compute_array_sequencer.md
# compute_array_sequencer

Command-side driver for the modular compute array. It accepts one vector command per handshake (add, subtract or Montgomery multiply across all lanes, one limb ID) and registers the operands onto the array's flattened input buses. It tracks each command through the array's fixed add/mul latencies and captures the matching output bus into an in-order result FIFO with ready/valid backpressure. The array itself has no flow control, so this block issues a command only when result storage and ordering are both guaranteed.

## Interface
- DATA_WIDTH, 50, bits per lane coefficient
- ARRAY_SIZE, 256, lanes per beat
- TAG_WIDTH, 8, opaque command tag returned with the result
- ADD_LATENCY, 2, cycles from array input buses driven to add_out_bus valid (≥1)
- MUL_LATENCY, 6, cycles from array input buses driven to mult_out_bus valid (> ADD_LATENCY)
- RES_DEPTH, 4, result FIFO entries (≥2)

- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_op  in  2  0=add, 1=sub, 2=mul, 3=reserved
- cmd_limb_id  in  6  limb ID 0..32, broadcast to every lane
- cmd_tag  in  TAG_WIDTH  returned on res_tag
- cmd_in0, cmd_in1  in  ARRAY_SIZE*DATA_WIDTH  operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- ctrl_ma  out  1  0=add, 1=subtract
- limb_id_add_bus, limb_id_mul_bus  out  ARRAY_SIZE*6  per-lane limb IDs
- add_in0_bus, add_in1_bus, mult_in0_bus, mult_in1_bus  out  ARRAY_SIZE*DATA_WIDTH  array operands
- add_out_bus, mult_out_bus  in  ARRAY_SIZE*DATA_WIDTH  array results
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer pops when res_valid && res_ready
- res_data  out  ARRAY_SIZE*DATA_WIDTH  result lanes
- res_tag  out  TAG_WIDTH  tag of the result
- res_op  out  2  op of the result
- err_reserved_op  out  1  sticky; set when an op-3 command is accepted

## Operation
- Issue (cycle T): all array-driving outputs are registered. At T+1 the chosen side carries cmd_in0/in1 and the limb ID replicated ARRAY_SIZE times. The unused side's operand and limb buses are 0. ctrl_ma = (op==1).
- Non-issue cycles: all array-driving outputs are 0.
- In-flight tracking:
  - A valid/op/tag shift pipeline of depth MUL_LATENCY+1.
  - An add/sub entry completes ADD_LATENCY cycles after T+1; a mul entry completes MUL_LATENCY cycles after T+1.
  - On completion, add_out_bus or mult_out_bus is written into the FIFO with its tag and op in that same cycle.
- drain: cycles until the latest scheduled completion, 0 when idle.
  - Load max(drain−1, L) on issue, where L is the command's latency; otherwise decrement toward 0.
- cmd_ready = (occupancy + inflight < RES_DEPTH) && (L_head > drain−1, i.e. the command at cmd_op would complete strictly after every in-flight one).
  - cmd_ready depends on cmd_op but never on cmd_valid.
  - This rule guarantees in-order results and at most one FIFO write per cycle.
- Reserved op 3: accepted when inflight==0. No array activity, no result. Sets err_reserved_op, which is cleared only by rst.
- FIFO: depth RES_DEPTH, first-word-fall-through. Write and pop in the same cycle are both performed. The credit check makes overflow impossible; an overflow is an assertion failure.
- Reset: clears the pipeline, drain, FIFO pointers, occupancy and err_reserved_op. In-flight results are discarded. Array outputs return from the hardware within MUL_LATENCY cycles and are ignored.

## Timing
- Reset values:
  - cmd_ready = 1 (FIFO empty, idle).
  - res_valid = 0.
  - res_data, res_tag and res_op = 0.
  - All array buses = 0, ctrl_ma = 0.
  - err_reserved_op = 0.
- Add latency: accepted at T → res_valid at T+ADD_LATENCY+2 (default T+4).
- Mul latency: accepted at T → res_valid at T+MUL_LATENCY+2 (default T+8).
- Throughput:
  - Back-to-back adds: 1 per cycle.
  - Back-to-back muls: 1 per cycle.
  - An add after a mul stalls until drain−1 < ADD_LATENCY (default: 4 stall cycles).
  - A mul after an add issues immediately.
- With res_ready held 0, cmd_ready drops once occupancy+inflight = RES_DEPTH. It reasserts the cycle after the first pop.

## Test plan
- Reset check: rst 3 cycles, then idle → all outputs 0 except cmd_ready=1. Hold for 10 cycles; no bus activity.
- Single add: limb 0, lane0 in0=5, in1=7, tag 0x11. Expect at T+1: add_in0_bus lane0=5, limb_id_add_bus all 0, mult buses 0, ctrl_ma=0. Expect at T+4: res_valid, res_data lane0=12, res_tag=0x11, res_op=0.
- Subtract wrap: limb 0, lane0 3−5 → ctrl_ma=1 at T+1; res_data lane0 = q0−2.
- Mul then add ordering: mul (tag 1, in0=0) at T=0, add (tag 2) offered at T=1. Expect cmd_ready=0 for cycles 1–4 and add accepted at cycle 5. Results emerge tags 1 then 2; mul lane values 0.
- Backpressure: res_ready=0, push 6 adds. Exactly 4 accepted and cmd_ready=0 thereafter. Raise res_ready → 4 results in tag order, then the remaining 2 complete.
- Reserved op and mid-flight reset:
  - op 3 at idle → accepted, err_reserved_op=1, no result.
  - Then issue 2 muls, assert rst at T+3 → res_valid never rises; err_reserved_op=0 and cmd_ready=1 after reset.
